fir_coeff_loader: RTL and testbench

- Configuration controller for the FIR tap datapath.
- Accepts a serial stream of coefficients over a valid/ready interface into a shadow bank.
- Commits the shadow bank atomically to the live packed coefficient bus, but only on a filter sample boundary, so the filter never computes with a half-updated tap set.
- Sits between the register/control interface and the FIR's packed coefficient input.

---
 rtl/fir_coeff_loader.sv | 72 +++++++
 tb/tb_fir_coeff_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: serial coefficient loader with atomic commit on a sample boundary
module fir_coeff_loader #(
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS = 4,
  parameter int IDX_WIDTH = 2,
  parameter logic [COEFF_WIDTH*NUM_TAPS-1:0] RESET_COEFF = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_start,
  input  logic                            cfg_abort,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [COEFF_WIDTH-1:0]          cfg_data,
  input  logic                            sample_tick,
  output logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeff,
  output logic                            busy,
  output logic                            commit_done
);
  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_TAPS - 1);
  state_t                          state_q, state_d;
  logic [IDX_WIDTH-1:0]            idx_q, idx_d;
  logic [COEFF_WIDTH*NUM_TAPS-1:0] shadow_q, shadow_d;
  logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_q, packed_d;
  logic                            done_q, done_d;
  logic                            accept;
  assign cfg_ready    = state_q == LOAD;
  assign busy         = state_q != IDLE;
  assign packed_coeff = packed_q;
  assign commit_done  = done_q;
  assign accept       = cfg_valid && cfg_ready;
  // next state: abort beats restart, restart beats accept/tick
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    packed_d = packed_q;
    done_d   = 1'b0;
    if (cfg_abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (cfg_start) begin
      state_d = LOAD;
      idx_d   = '0;
    end else if (state_q == LOAD && accept) begin
      shadow_d[int'(idx_q)*COEFF_WIDTH +: COEFF_WIDTH] = cfg_data;
      state_d = idx_q == LAST ? ARMED : LOAD;
      idx_d   = idx_q == LAST ? '0 : idx_q + IDX_WIDTH'(1);
    end else if (state_q == ARMED && sample_tick) begin
      packed_d = shadow_q;
      done_d   = 1'b1;
      state_d  = IDLE;
    end
  end
  // state, shadow bank and live bus registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      packed_q <= RESET_COEFF;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      packed_q <= packed_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed plus random stimulus against a queue-based reference model
module tb_fir_coeff_loader;
  localparam int CW = 8;
  localparam int NT = 4;
  localparam logic [CW*NT-1:0] RC = '0;
  logic clk = 0, rst_n = 0, cfg_start = 0, cfg_abort = 0, cfg_valid = 0, sample_tick = 0;
  logic [CW-1:0] cfg_data = '0;
  logic cfg_ready, busy, commit_done;
  logic [CW*NT-1:0] packed_coeff;
  logic [CW*NT-1:0] m_live = RC, m_bank = '0;
  logic [CW-1:0] m_words[$];
  bit m_loading = 0, m_armed = 0, m_done = 0;
  int n_chk = 0, n_fail = 0;

  fir_coeff_loader #(.COEFF_WIDTH(CW), .NUM_TAPS(NT), .IDX_WIDTH(2), .RESET_COEFF(RC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .sample_tick(sample_tick), .packed_coeff(packed_coeff), .busy(busy),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, s, a, v, input logic [CW-1:0] d, input logic t);
    m_done = 0;
    if (!r) begin
      m_live = RC; m_loading = 0; m_armed = 0; m_words.delete();
    end else if (a) begin
      m_loading = 0; m_armed = 0; m_words.delete();
    end else if (s) begin
      m_loading = 1; m_armed = 0; m_words.delete();
    end else if (m_loading && v) begin
      m_words.push_back(d);
      if (m_words.size() == NT) begin
        for (int i = 0; i < NT; i++) m_bank[CW*i +: CW] = m_words[i];
        m_words.delete(); m_loading = 0; m_armed = 1;
      end
    end else if (m_armed && t) begin
      m_live = m_bank; m_done = 1; m_armed = 0;
    end
  endtask

  task automatic cyc(input logic r, s, a, v, input logic [CW-1:0] d, input logic t);
    rst_n = r; cfg_start = s; cfg_abort = a; cfg_valid = v; cfg_data = d; sample_tick = t;
    @(posedge clk);
    model(r, s, a, v, d, t);
    #1;
    check("packed", packed_coeff, m_live);
    check("busy", busy, m_loading || m_armed);
    check("ready", cfg_ready, m_loading);
    check("done", commit_done, m_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic feed(input logic [CW-1:0] d);
    cyc(1, 0, 0, 1, d, 0);
  endtask

  task automatic load4(input logic [31:0] w);
    cyc(1, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < NT; i++) feed(w[8*i +: 8]);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 8'h00, 0);
    check("rst_packed", packed_coeff, 32'h0);
    idle(10);
    load4(32'h04030201);
    idle(4);
    check("armed_hold", packed_coeff, 32'h0);
    cyc(1, 0, 0, 0, 8'h00, 1);
    check("tp2_packed", packed_coeff, 32'h04030201);
    check("tp2_done", commit_done, 1'b1);
    idle(1);
    check("tp2_done_drop", commit_done, 1'b0);
    check("tp2_busy", busy, 1'b0);
    load4(32'h55555555);
    cyc(1, 0, 0, 0, 8'h00, 1);
    idle(1);
    cyc(1, 1, 0, 0, 8'h00, 0);
    for (int i = 0, k = 0; i < 8; i++) begin
      cyc(1, 0, 0, i % 2 == 0, 8'(k + 1), 0);
      if (i % 2 == 0) k++;
    end
    check("toggle_armed", busy, 1'b1);
    cyc(1, 0, 0, 0, 8'h00, 1);
    check("toggle_packed", packed_coeff, 32'h04030201);
    cyc(1, 1, 0, 0, 8'h00, 0);
    feed(8'h11); feed(8'h22);
    cyc(1, 0, 1, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 1);
    check("abort_packed", packed_coeff, 32'h04030201);
    check("abort_done", commit_done, 1'b0);
    load4(32'h99999999);
    cyc(1, 0, 0, 0, 8'h00, 1);
    cyc(1, 1, 0, 0, 8'h00, 0);
    feed(8'hAA); feed(8'hBB);
    cyc(1, 1, 0, 1, 8'hCC, 0);
    for (int i = 0; i < NT; i++) feed(8'(i + 1));
    cyc(1, 0, 0, 0, 8'h00, 1);
    check("restart_packed", packed_coeff, 32'h04030201);
    load4(32'hDEADBEEF);
    cyc(1, 0, 1, 0, 8'h00, 1);
    check("abort_tick_done", commit_done, 1'b0);
    check("abort_tick_packed", packed_coeff, 32'h04030201);
    load4(32'h12345678);
    cyc(0, 0, 0, 0, 8'h00, 1);
    check("rst_armed_packed", packed_coeff, 32'h0);
    check("rst_armed_busy", busy, 1'b0);
    idle(2);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 1) == 1, 8'($urandom()), $urandom_range(0, 3) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
